// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus master and CPU decode.
// Contents:
//   SIZE_* : access size codes carried on the size port.
//   BE_ALL : full-word byte enable; Mem zeroes unselected lanes, so only this is used.
//   state_t: bus master FSM state encoding.
//   access_illegal(): illegal-size / misalignment test used at request check time.
package mem_bus_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam logic [3:0] BE_ALL = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CHECK    = 3'd1,
      ST_RD_ISSUE = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_WR_ISSUE = 3'd4,
      ST_DONE     = 3'd5,
      ST_ERR      = 3'd6
   } state_t;

   // Illegal size code, odd half address, or word address not on a 4-byte boundary.
   function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] off);
      return (size == SIZE_ILL) ||
             ((size == SIZE_HALF) && off[0]) ||
             ((size == SIZE_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment for the data-memory bus master.
// Ports:
//   word_i     in  32  word read from Mem
//   size_i     in  2   access size code
//   sign_ext_i in  1   1 = sign-extend sub-word loads, 0 = zero-extend
//   byte_off_i in  2   byte address bits [1:0]
//   wdata_i    in  32  right-justified store data
//   load_o     out 32  extracted and extended load value
//   merge_o    out 32  word_i with the addressed lane(s) replaced by wdata_i
module mem_lane_align
   import mem_bus_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [1:0]  byte_off_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
      half_sel = word_i[{byte_off_i[1], 4'b0000} +: 16];
      load_o   = word_i;
      merge_o  = wdata_i;
      case (size_i)
         SIZE_BYTE: begin
            load_o  = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            merge_o = word_i;
            merge_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SIZE_HALF: begin
            load_o  = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            merge_o = word_i;
            merge_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_bus_master.sv
// Load/store initiator between the CPU MEM stage and the word-addressed data memory.
// Takes one byte/half/word access, issues full-word Mem cycles (read-modify-write for
// sub-word stores) and returns extended load data. All outputs are registered.
// Ports:
//   Clk, Reset (async, active-high)
//   req/we/size/sign_ext/addr/wdata : CPU request, latched when accepted in IDLE
//   busy/done/err/rdata             : CPU status and load result
//   Mem_CS/RW/BE/Addr/DataOut       : Mem command (RW must only be high in WR_ISSUE)
//   Mem_DataIn/Mem_DataReady        : Mem read return
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int TO_W        = 5
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        Mem_CS,
   output logic        Mem_RW,
   output logic [3:0]  Mem_BE,
   output logic [29:0] Mem_Addr,
   output logic [31:0] Mem_DataOut,
   input  logic [31:0] Mem_DataIn,
   input  logic        Mem_DataReady
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            we_q, we_d, sext_q, sext_d;
   logic [1:0]      size_q, size_d;
   logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic            cs_q, cs_d, rw_q, rw_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     rdata_q, rdata_d, dout_q, dout_d;
   logic [29:0]     maddr_q, maddr_d;
   logic [31:0]     load_val, merge_val;

   mem_lane_align u_align (
      .word_i     (Mem_DataIn),
      .size_i     (size_q),
      .sign_ext_i (sext_q),
      .byte_off_i (addr_q[1:0]),
      .wdata_i    (wdata_q),
      .load_o     (load_val),
      .merge_o    (merge_val)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cs_q    <= 1'b0;
         rw_q    <= 1'b0;
         be_q    <= 4'b0000;
         rdata_q <= '0;
         dout_q  <= '0;
         maddr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         sext_q  <= sext_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cs_q    <= cs_d;
         rw_q    <= rw_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         dout_q  <= dout_d;
         maddr_q <= maddr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      sext_d  = sext_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      dout_d  = dout_q;
      maddr_d = maddr_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               we_d    = we;
               sext_d  = sign_ext;
               size_d  = size;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (access_illegal(size_q, addr_q[1:0])) begin
               state_d = ST_ERR;
            end else if (we_q && (size_q == SIZE_WORD)) begin
               dout_d  = wdata_q;
               state_d = ST_WR_ISSUE;
            end else begin
               state_d = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (Mem_DataReady) begin
               if (we_q) begin
                  dout_d  = merge_val;
                  state_d = ST_WR_ISSUE;
               end else begin
                  rdata_d = load_val;
                  state_d = ST_DONE;
               end
            end else if ((cnt_q + TO_W'(1)) == TO_LIMIT) begin
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         ST_WR_ISSUE: state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         ST_ERR:      state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet line up
      // with the state they describe.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
      cs_d   = (state_d == ST_RD_ISSUE) || (state_d == ST_WR_ISSUE);
      rw_d   = (state_d == ST_WR_ISSUE);
      be_d   = cs_d ? BE_ALL : 4'b0000;
      if (cs_d) begin
         maddr_d = addr_d[31:2];
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign rdata       = rdata_q;
   assign Mem_CS      = cs_q;
   assign Mem_RW      = rw_q;
   assign Mem_BE      = be_q;
   assign Mem_Addr    = maddr_q;
   assign Mem_DataOut = dout_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed scenarios followed by random
// accesses, all checked against a reference model of memory contents, access
// results, latency and Mem traffic.
module tb_mem_bus_master;

   localparam int TIMEOUT_CYC = 16;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0, wdata = '0;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic        Mem_CS, Mem_RW;
   logic [3:0]  Mem_BE;
   logic [29:0] Mem_Addr;
   logic [31:0] Mem_DataOut;
   logic [31:0] Mem_DataIn = '0;
   logic        Mem_DataReady = 1'b0;

   mem_bus_master #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
      .Mem_CS(Mem_CS), .Mem_RW(Mem_RW), .Mem_BE(Mem_BE), .Mem_Addr(Mem_Addr),
      .Mem_DataOut(Mem_DataOut), .Mem_DataIn(Mem_DataIn), .Mem_DataReady(Mem_DataReady)
   );

   always #5 Clk = ~Clk;

   // ---------------- memory model (256 words) ----------------
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic        stall_ready = 1'b0;
   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;
   int          cs_cycles = 0, rw_cycles = 0, proto_bad = 0;
   logic [29:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   always @(posedge Clk) begin
      if (pre_en) mem[pre_idx] = pre_val;
      if (Mem_CS) cs_cycles++;
      if (Mem_CS ? (Mem_BE != 4'hF) : (Mem_BE != 4'h0)) proto_bad++;
      if (Mem_RW) begin
         rw_cycles++;
         if (!Mem_CS) proto_bad++;
         mem[Mem_Addr[7:0]] = Mem_DataOut;
         last_wr_addr = Mem_Addr;
         last_wr_data = Mem_DataOut;
      end
      if (Mem_CS && !Mem_RW && !stall_ready) begin
         Mem_DataIn    <= mem[Mem_Addr[7:0]];
         Mem_DataReady <= 1'b1;
      end else begin
         Mem_DataReady <= 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_rdata = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic ref_is_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic sx);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         if (sx && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
         if (sx && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] mask;
      int sh;
      if (sz == 2'd0) begin
         sh = 8 * int'(a % 4);
         mask = 32'hFF << sh;
      end else if (sz == 2'd1) begin
         sh = 16 * int'((a % 4) / 2);
         mask = 32'hFFFF << sh;
      end else begin
         return d;
      end
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_word(input int idx, input logic [31:0] v);
      @(negedge Clk);
      pre_en = 1'b1; pre_idx = 8'(idx); pre_val = v;
      ref_mem[idx] = v;
      @(negedge Clk);
      pre_en = 1'b0;
   endtask

   task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] d, input bit hold);
      int exp_lat, exp_cs, exp_rw, lat, cs0, rw0, bad0, busy_bad;
      logic exp_err, got_done, got_err;
      logic [31:0] word;
      int idx;
      idx = int'(a[9:2]);
      word = ref_mem[idx];
      exp_err = ref_is_err(sz, a);
      if (exp_err) begin
         exp_lat = 2; exp_cs = 0; exp_rw = 0;
      end else if (w && sz == 2'd2) begin
         exp_lat = 3; exp_cs = 1; exp_rw = 1;
         ref_mem[idx] = d;
      end else if (stall_ready) begin
         exp_err = 1'b1; exp_lat = 3 + TIMEOUT_CYC; exp_cs = 1; exp_rw = 0;
      end else if (!w) begin
         exp_lat = 4; exp_cs = 1; exp_rw = 0;
         exp_rdata = ref_load(word, a, sz, sx);
      end else begin
         exp_lat = 5; exp_cs = 2; exp_rw = 1;
         ref_mem[idx] = ref_merge(word, a, sz, d);
      end

      cs0 = cs_cycles; rw0 = rw_cycles; bad0 = proto_bad; busy_bad = 0;
      @(negedge Clk);
      req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
      @(posedge Clk);
      lat = 0; got_done = 1'b0; got_err = 1'b0;
      for (int c = 1; c <= 40 && !(got_done || got_err); c++) begin
         @(negedge Clk);
         if (c == 1) begin
            // Later input changes must not affect the accepted access.
            req = hold; addr = $urandom; wdata = $urandom;
            size = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
            sign_ext = 1'($urandom_range(0, 1));
         end
         if (!busy) busy_bad++;
         got_done = done; got_err = err; lat = c;
      end
      req = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      check("done_pulse", 32'(got_done), 32'(!exp_err));
      check("err_pulse", 32'(got_err), 32'(exp_err));
      check("busy_during", 32'(busy_bad), 32'd0);
      @(negedge Clk);
      check("idle_after", {29'd0, busy, done, err}, 32'd0);
      check("cs_cycles", 32'(cs_cycles - cs0), 32'(exp_cs));
      check("rw_cycles", 32'(rw_cycles - rw0), 32'(exp_rw));
      check("protocol", 32'(proto_bad - bad0), 32'd0);
      check("rdata", rdata, exp_rdata);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int rw0, bad;
      logic [1:0] rsz;
      int r;

      repeat (3) @(negedge Clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_cs", 32'(Mem_CS), 32'd0);
      check("rst_rw", 32'(Mem_RW), 32'd0);
      check("rst_be", 32'(Mem_BE), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_addr", 32'(Mem_Addr), 32'd0);
      check("rst_dout", Mem_DataOut, 32'd0);
      Reset = 1'b0;

      for (int i = 0; i < 256; i++) set_word(i, $urandom);

      // Word store then word load.
      run_access(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0);
      check("sw_addr", 32'(last_wr_addr), 32'd8);
      check("sw_data", last_wr_data, 32'hDEAD_BEEF);
      run_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
      check("lw_value", rdata, 32'hDEAD_BEEF);

      // Sub-word loads.
      set_word(9, 32'h1122_3344);
      run_access(1'b0, 2'd0, 1'b1, 32'h27, 32'h0, 1'b0);
      check("lb_27", rdata, 32'h0000_0011);
      run_access(1'b0, 2'd1, 1'b0, 32'h26, 32'h0, 1'b1);
      check("lh_26", rdata, 32'h0000_1122);
      set_word(9, 32'h0000_00F0);
      run_access(1'b0, 2'd0, 1'b1, 32'h24, 32'h0, 1'b0);
      check("lb_sx", rdata, 32'hFFFF_FFF0);
      run_access(1'b0, 2'd0, 1'b0, 32'h24, 32'h0, 1'b0);
      check("lb_zx", rdata, 32'h0000_00F0);

      // Sub-word stores (read-modify-write).
      set_word(9, 32'h1122_3344);
      run_access(1'b1, 2'd0, 1'b0, 32'h25, 32'h0000_00AB, 1'b0);
      check("sb_25", mem[9], 32'h1122_AB44);
      set_word(9, 32'h1122_3344);
      run_access(1'b1, 2'd1, 1'b0, 32'h26, 32'h0000_5566, 1'b0);
      check("sh_26", mem[9], 32'h5566_3344);

      // Error cases: no Mem access, rdata held.
      run_access(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0);
      run_access(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, 1'b0);
      run_access(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b0);

      // Timeout, then recovery.
      stall_ready = 1'b1;
      run_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
      stall_ready = 1'b0;
      run_access(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b0);

      // Random accesses.
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         rsz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         run_access(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 1)));
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("mem_image", 32'(bad), 32'd0);

      // Reset in RD_WAIT of a byte store: no write may follow.
      set_word(12, 32'hCAFE_F00D);
      @(negedge Clk);
      req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h31; wdata = 32'h77;
      @(posedge Clk);
      @(negedge Clk); req = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("mid_busy", 32'(busy), 32'd1);
      rw0 = rw_cycles;
      Reset = 1'b1;
      #1;
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_rw", 32'(Mem_RW), 32'd0);
      check("rst_async_cs", 32'(Mem_CS), 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      exp_rdata = '0;
      repeat (10) @(negedge Clk);
      check("no_late_write", 32'(rw_cycles - rw0), 32'd0);
      check("word_kept", mem[12], 32'hCAFE_F00D);
      check("rdata_cleared", rdata, exp_rdata);
      run_access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
